// File: rtl/hyst_pkg.sv
// Shared types and helpers for the systolic array edge blocks.
// Lane type and packed-lane slicing used by deskew logic and its users.
package hyst_pkg;

  localparam int DEF_REG_WIDTH = 16;
  localparam int DEF_VECTOR    = 4;

  typedef logic [DEF_REG_WIDTH-1:0] lane_t;

  function automatic lane_t lane_sel(
    input logic [DEF_VECTOR*DEF_REG_WIDTH-1:0] vec,
    input int                                  i
  );
    return vec[i*DEF_REG_WIDTH +: DEF_REG_WIDTH];
  endfunction

endpackage

// File: rtl/hyst_sync_fifo.sv
// Synchronous FIFO with a registered head output.
// dout always mirrors the oldest entry; it is valid while empty is low.
module hyst_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    rd_nxt;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign rd_en  = pop && !empty;
  assign wr_en  = push && (!full || rd_en);
  assign rd_nxt = rd_q + AW'(1);
  assign dout   = dout_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (wr_en) wr_d = wr_q + AW'(1);
    if (rd_en) rd_d = rd_nxt;
    if (wr_en && !rd_en) cnt_d = cnt_q + (AW+1)'(1);
    if (rd_en && !wr_en) cnt_d = cnt_q - (AW+1)'(1);
    // Head register refills from the next slot, or straight from din
    if (rd_en) begin
      if (cnt_q >= (AW+1)'(2)) dout_d = mem_q[rd_nxt];
      else if (wr_en)          dout_d = din;
    end else if (empty && wr_en) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      if (wr_en) mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/systolic_output_deskew.sv
// Realigns skewed array output rows into full vectors and buffers them.
// Lane i is delayed VECTOR-1-i cycles so every lane lands together.
module systolic_output_deskew
  import hyst_pkg::*;
#(
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int VECTOR     = DEF_VECTOR,
  parameter int FIFO_DEPTH = 4,
  parameter int ROWS       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [VECTOR*REG_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [VECTOR*REG_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        overflow
);

  localparam int VW = VECTOR * REG_WIDTH;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [VECTOR-2:0] vpipe_q, vpipe_d;
  logic [VW-1:0]     aligned;
  logic [RW-1:0]     row_q, row_d;
  logic              ovf_q, ovf_d;
  logic              push_req;
  logic              row_last;
  logic              pop;
  logic              full;
  logic              empty;
  logic [VW:0]       fifo_dout;

  for (genvar i = 0; i < VECTOR - 1; i++) begin : g_lane
    localparam int D = VECTOR - 1 - i;
    logic [REG_WIDTH-1:0] dly_q [D];
    logic [REG_WIDTH-1:0] dly_d [D];

    always_comb begin
      dly_d[0] = in_data[i*REG_WIDTH +: REG_WIDTH];
      for (int k = 1; k < D; k++) dly_d[k] = dly_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < D; k++) dly_q[k] <= '0;
      end else begin
        dly_q <= dly_d;
      end
    end

    assign aligned[i*REG_WIDTH +: REG_WIDTH] = dly_q[D-1];
  end

  assign aligned[(VECTOR-1)*REG_WIDTH +: REG_WIDTH] =
    in_data[(VECTOR-1)*REG_WIDTH +: REG_WIDTH];

  assign push_req = vpipe_q[VECTOR-2];
  assign row_last = (row_q == RW'(ROWS - 1));
  assign pop      = out_ready && !empty;

  always_comb begin
    vpipe_d[0] = in_valid;
    for (int k = 1; k < VECTOR - 1; k++) vpipe_d[k] = vpipe_q[k-1];
  end

  // Dropped rows still advance the row count to keep tile framing
  always_comb begin
    row_d = row_q;
    ovf_d = ovf_q;
    if (push_req) row_d = row_last ? '0 : row_q + RW'(1);
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q <= '0;
      row_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vpipe_q <= vpipe_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
    end
  end

  hyst_sync_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   ({row_last, aligned}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = fifo_dout[VW-1:0];
  assign out_last  = fifo_dout[VW] && !empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew.
// Each task drives skewed rows and checks the realigned output stream.
module tb_systolic_output_deskew;
  import hyst_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_last;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  systolic_output_deskew #(
    .REG_WIDTH  (16),
    .VECTOR     (4),
    .FIFO_DEPTH (4),
    .ROWS       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_vec(input logic [15:0] base,
                                          input int r);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = base + 16'(r*16 + i);
    return v;
  endfunction

  // Cycle c relative to first row; row r starts at cycle r
  task automatic drive(input int c, input int nrows,
                       input logic [15:0] base);
    logic [63:0] v;
    int r;
    in_valid = (c >= 0) && (c < nrows);
    for (int i = 0; i < 4; i++) begin
      r = c - i;
      if (r >= 0 && r < nrows) v[i*16 +: 16] = base + 16'(r*16 + i);
      else                     v[i*16 +: 16] = 16'($urandom);
    end
    in_data = v;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    if (out_data !== 64'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", out_data);
    end
    if (out_last !== 1'b0) begin
      n_err++; $display("FAIL reset_last: got %b expected 0", out_last);
    end
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_row();
    lane_t l;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(c, 1, 16'h00A0);
      n_cmp++;
      if (out_valid !== (c == 4)) begin
        n_err++;
        $display("FAIL single_valid c=%0d: got %b expected %b",
                 c, out_valid, (c == 4));
      end
      if (c == 4) begin
        n_cmp += 2;
        if (out_data !== 64'h00A3_00A2_00A1_00A0) begin
          n_err++;
          $display("FAIL single_data: got %h expected %h",
                   out_data, 64'h00A3_00A2_00A1_00A0);
        end
        if (out_last !== 1'b0) begin
          n_err++; $display("FAIL single_last: got %b expected 0", out_last);
        end
        for (int i = 0; i < 4; i++) begin
          l = lane_sel(out_data, i);
          n_cmp++;
          if (l !== 16'h00A0 + 16'(i)) begin
            n_err++;
            $display("FAIL single_lane%0d: got %h expected %h",
                     i, l, 16'h00A0 + 16'(i));
          end
        end
      end
      step();
    end
  endtask

  task automatic test_streaming();
    logic ev;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(c, 4, 16'h0000);
      ev = (c >= 4) && (c <= 7);
      n_cmp += 2;
      if (out_valid !== ev) begin
        n_err++;
        $display("FAIL stream_valid c=%0d: got %b expected %b", c, out_valid, ev);
      end
      if (overflow !== 1'b0) begin
        n_err++; $display("FAIL stream_ovf c=%0d: got %b expected 0", c, overflow);
      end
      if (ev) begin
        n_cmp += 2;
        if (out_data !== exp_vec(16'h0000, c - 4)) begin
          n_err++;
          $display("FAIL stream_data c=%0d: got %h expected %h",
                   c, out_data, exp_vec(16'h0000, c - 4));
        end
        if (out_last !== (c == 7)) begin
          n_err++;
          $display("FAIL stream_last c=%0d: got %b expected %b",
                   c, out_last, (c == 7));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic ev;
    int   r;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      drive(c, 5, 16'h0100);
      out_ready = (c >= 9);
      ev = (c >= 4) && (c <= 12);
      r  = (c < 9) ? 0 : c - 9;
      n_cmp += 2;
      if (out_valid !== ev) begin
        n_err++;
        $display("FAIL bp_valid c=%0d: got %b expected %b", c, out_valid, ev);
      end
      if (overflow !== (c >= 8)) begin
        n_err++;
        $display("FAIL bp_ovf c=%0d: got %b expected %b", c, overflow, (c >= 8));
      end
      if (ev) begin
        n_cmp += 2;
        if (out_data !== exp_vec(16'h0100, r)) begin
          n_err++;
          $display("FAIL bp_data c=%0d: got %h expected %h",
                   c, out_data, exp_vec(16'h0100, r));
        end
        if (out_last !== (r == 3)) begin
          n_err++;
          $display("FAIL bp_last c=%0d: got %b expected %b", c, out_last, (r == 3));
        end
      end
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_full_pop();
    logic ev;
    int   r;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(c, 5, 16'h0200);
      out_ready = (c >= 7);
      ev = (c >= 4) && (c <= 11);
      r  = (c <= 7) ? 0 : c - 7;
      n_cmp += 2;
      if (out_valid !== ev) begin
        n_err++;
        $display("FAIL fp_valid c=%0d: got %b expected %b", c, out_valid, ev);
      end
      if (overflow !== 1'b0) begin
        n_err++; $display("FAIL fp_ovf c=%0d: got %b expected 0", c, overflow);
      end
      if (ev) begin
        n_cmp += 2;
        if (out_data !== exp_vec(16'h0200, r)) begin
          n_err++;
          $display("FAIL fp_data c=%0d: got %h expected %h",
                   c, out_data, exp_vec(16'h0200, r));
        end
        if (out_last !== (r == 3)) begin
          n_err++;
          $display("FAIL fp_last c=%0d: got %b expected %b", c, out_last, (r == 3));
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic ev;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(c, 5, 16'h0300);
      out_ready = 1'b0;
      step();
    end
    n_cmp += 2;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL rm_pre_ovf: got %b expected 1", overflow);
    end
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL rm_pre_valid: got %b expected 1", out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      drive(c, 1, 16'h0400);
      if (c < 2) step();
    end
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rm_valid: got %b expected 0", out_valid);
    end
    if (out_data !== 64'h0) begin
      n_err++; $display("FAIL rm_data: got %h expected 0", out_data);
    end
    if (out_last !== 1'b0) begin
      n_err++; $display("FAIL rm_last: got %b expected 0", out_last);
    end
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL rm_ovf: got %b expected 0", overflow);
    end
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(c + 10, 0, 16'h0000);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL rm_stale c=%0d: got %b expected 0", c, out_valid);
      end
      step();
    end
    for (int c = 0; c < 10; c++) begin
      drive(c, 4, 16'h0500);
      ev = (c >= 4) && (c <= 7);
      n_cmp++;
      if (out_valid !== ev) begin
        n_err++;
        $display("FAIL rm_new_valid c=%0d: got %b expected %b", c, out_valid, ev);
      end
      if (ev) begin
        n_cmp += 2;
        if (out_data !== exp_vec(16'h0500, c - 4)) begin
          n_err++;
          $display("FAIL rm_new_data c=%0d: got %h expected %h",
                   c, out_data, exp_vec(16'h0500, c - 4));
        end
        if (out_last !== (c == 7)) begin
          n_err++;
          $display("FAIL rm_new_last c=%0d: got %b expected %b",
                   c, out_last, (c == 7));
        end
      end
      step();
    end
  endtask

  task automatic test_lane_isolation();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(c, 0, 16'h0000);
      n_cmp += 2;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL iso_valid c=%0d: got %b expected 0", c, out_valid);
      end
      if (overflow !== 1'b0) begin
        n_err++; $display("FAIL iso_ovf c=%0d: got %b expected 0", c, overflow);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_streaming();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_lane_isolation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
